reg_bus_arbiter: RTL and testbench

//  Two-master arbiter/sequencer for the 16-bit register access port (addr_ctrl/data_in/data_out).

---
 rtl/reg_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//   Two-master round-robin arbiter/sequencer for the 16-bit-addressed register
//   access port. Each master issues single read/write requests; the winner is
//   latched, driven onto the register port for one select cycle, and (for
//   reads) the registered read data is captured after RD_LAT cycles. A
//   one-cycle ack (with err for out-of-range addresses) closes each access.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   mX_req/wr/addr/wdata   master X request, direction, address, write data
//   mX_ack/err/rdata       master X completion pulse, range error, read data
//   bus_addr_ctrl  {addr[15:0], 14'b0, read, select} to the register block
//   bus_data_in    write data to the register block
//   bus_data_out   registered read data from the register block
//   busy           high whenever a transaction is in flight
// ---------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int unsigned RD_LAT   = 1,
    parameter logic [15:0] MAX_ADDR = 16'h000A,
    parameter bit          RR_INIT  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr_ctrl,
    output logic [31:0] bus_data_in,
    input  logic [31:0] bus_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    state_t      state_reg, state_next;
    logic        rr_ptr_reg;
    logic        gnt_id_reg;
    logic        gnt_rd_reg;     // stored as "read" so the reset value drives 0 on the bus
    logic [15:0] gnt_addr_reg;
    logic [31:0] gnt_wdata_reg;
    logic [3:0]  wait_cnt_reg;
    logic [31:0] m0_rdata_reg;
    logic [31:0] m1_rdata_reg;

    logic        grant_valid;
    logic        grant_id;
    logic        in_range;
    logic        select;

    // Contention goes to the pointer master; a lone requester always wins.
    always_comb begin
        grant_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            grant_id = rr_ptr_reg;
        end else begin
            grant_id = m1_req;
        end
    end

    assign in_range = (gnt_addr_reg <= MAX_ADDR);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  state_next = gnt_rd_reg ? WAIT : DONE;
            WAIT:    if (wait_cnt_reg == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant latch, round-robin pointer, wait counter and read-data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg    <= RR_INIT;
            gnt_id_reg    <= 1'b0;
            gnt_rd_reg    <= 1'b0;
            gnt_addr_reg  <= 16'h0;
            gnt_wdata_reg <= 32'h0;
            wait_cnt_reg  <= 4'd0;
            m0_rdata_reg  <= 32'h0;
            m1_rdata_reg  <= 32'h0;
        end else begin
            if (state_reg == IDLE && grant_valid) begin
                // Whoever wins, the other master gets priority next time.
                rr_ptr_reg    <= ~grant_id;
                gnt_id_reg    <= grant_id;
                gnt_rd_reg    <= grant_id ? ~m1_wr    : ~m0_wr;
                gnt_addr_reg  <= grant_id ? m1_addr   : m0_addr;
                gnt_wdata_reg <= grant_id ? m1_wdata  : m0_wdata;
            end

            if (state_reg == ACCESS && gnt_rd_reg) begin
                wait_cnt_reg <= WAIT_LOAD;
            end else if (state_reg == WAIT && wait_cnt_reg != 4'd0) begin
                wait_cnt_reg <= wait_cnt_reg - 4'd1;
            end

            // Last WAIT cycle: register block data is valid now.
            if (state_reg == WAIT && wait_cnt_reg == 4'd0) begin
                if (gnt_id_reg) begin
                    m1_rdata_reg <= in_range ? bus_data_out : 32'h0;
                end else begin
                    m0_rdata_reg <= in_range ? bus_data_out : 32'h0;
                end
            end
        end
    end

    // Output decode
    always_comb begin
        busy   = (state_reg != IDLE);
        select = (state_reg == ACCESS) && in_range;
        m0_ack = (state_reg == DONE) && !gnt_id_reg;
        m1_ack = (state_reg == DONE) &&  gnt_id_reg;
        m0_err = m0_ack && !in_range;
        m1_err = m1_ack && !in_range;
        // Address/direction/data stay at the last granted values between accesses.
        bus_addr_ctrl = {gnt_addr_reg, 14'b0, gnt_rd_reg, select};
        bus_data_in   = gnt_wdata_reg;
        m0_rdata      = m0_rdata_reg;
        m1_rdata      = m1_rdata_reg;
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_arbiter
//   Directed bench for reg_bus_arbiter (RD_LAT=1, MAX_ADDR=0x000A, RR_INIT=0).
//   A small register-block model answers selected reads one cycle later and
//   returns 32'hDEAD_BEEF on every other cycle.
// ---------------------------------------------------------------------------
module tb_reg_bus_arbiter;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err, busy;
    logic [31:0] m0_rdata, m1_rdata, bus_addr_ctrl, bus_data_in;
    logic [31:0] bus_data_out = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    reg_bus_arbiter #(
        .RD_LAT   (RD_LAT),
        .MAX_ADDR (16'h000A),
        .RR_INIT  (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_req        (m0_req),
        .m0_wr         (m0_wr),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_ack        (m0_ack),
        .m0_err        (m0_err),
        .m0_rdata      (m0_rdata),
        .m1_req        (m1_req),
        .m1_wr         (m1_wr),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_ack        (m1_ack),
        .m1_err        (m1_err),
        .m1_rdata      (m1_rdata),
        .bus_addr_ctrl (bus_addr_ctrl),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .busy          (busy)
    );

    // Register block model, read latency 1
    logic [31:0] mem [16];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | i;
            mem_init_done <= 1'b1;
        end else if (bus_addr_ctrl[0]) begin
            if (bus_addr_ctrl[1]) begin
                bus_data_out <= mem[bus_addr_ctrl[19:16]];
            end else begin
                mem[bus_addr_ctrl[19:16]] <= bus_data_in;
                bus_data_out <= 32'hDEAD_BEEF;
            end
        end else begin
            bus_data_out <= 32'hDEAD_BEEF;
        end
    end

    logic [132:0] all_outs;
    assign all_outs = {m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
                       bus_addr_ctrl, bus_data_in, busy};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rd [2];

    typedef struct {
        bit          id;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;   // expected read data (reads only)
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit id, input bit req, input bit wr,
                         input logic [15:0] addr, input logic [31:0] wdata);
        if (id) begin
            m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
    endtask

    // One transaction from an idle arbiter; fields are scrambled after the
    // grant edge to confirm they were latched.
    task automatic run_single(input vec_t v, input int idx);
        int          cyc, sel_cnt, lat;
        bit          got, other_ack;
        logic [31:0] exp_ctrl, other_rd;
        exp_ctrl = {v.addr, 14'b0, ~v.wr, 1'b1};
        other_rd = exp_rd[v.id ^ 1'b1];
        if (!v.wr) exp_rd[v.id] = v.rdata;
        cyc = 0; sel_cnt = 0; lat = 0; got = 0; other_ack = 0;
        @(negedge clk);
        drive(v.id, 1'b1, v.wr, v.addr, v.wdata);
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) drive(v.id, 1'b1, ~v.wr, 16'h0003, 32'h5A5A_5A5A);
            if (bus_addr_ctrl[0]) begin
                sel_cnt++;
                check($sformatf("v%0d_ctrl", idx), bus_addr_ctrl, exp_ctrl);
                if (v.wr) check($sformatf("v%0d_wdata", idx), bus_data_in, v.wdata);
            end
            if (v.id ? m0_ack : m1_ack) other_ack = 1'b1;
            if (v.id ? m1_ack : m0_ack) begin
                got = 1'b1;
                lat = cyc;
                check($sformatf("v%0d_err", idx), v.id ? m1_err : m0_err, v.err);
                check($sformatf("v%0d_rdata", idx), v.id ? m1_rdata : m0_rdata, exp_rd[v.id]);
                drive(v.id, 1'b0, 1'b0, 16'h0, 32'h0);
            end
        end
        check($sformatf("v%0d_latency", idx), lat, v.wr ? 2 : 2 + RD_LAT);
        check($sformatf("v%0d_sel_count", idx), sel_cnt, v.err ? 0 : 1);
        check($sformatf("v%0d_other_ack", idx), other_ack, 1'b0);
        check($sformatf("v%0d_other_rdata", idx), v.id ? m0_rdata : m1_rdata, other_rd);
        @(negedge clk);
        check($sformatf("v%0d_idle_after", idx), {v.id ? m1_ack : m0_ack, busy}, 2'b00);
        $display("txn %0d: m%0d %s addr=%h lat=%0d err=%0b rdata0=%h rdata1=%h",
                 idx, v.id, v.wr ? "WR" : "RD", v.addr, lat, v.err, m0_rdata, m1_rdata);
    endtask

    initial begin
        int          c, served;
        bit          d0, d1, flag;
        logic [7:0]  seq;

        vecs[0] = '{1'b0, 1'b1, 16'h0000, 32'h1234_5678, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 16'h0001, 32'hCAFE_0001, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 16'h0001, 32'h0,         1'b0, 32'hCAFE_0001};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 16'h000A, 32'h0000_00AA, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 16'h000A, 32'h0,         1'b0, 32'h0000_00AA};
        vecs[6] = '{1'b1, 1'b0, 16'h000B, 32'h0,         1'b1, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 32'h7777_7777, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 16'h0020, 32'h0,         1'b1, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 16'h0005, 32'h0,         1'b0, 32'hA000_0005};

        // Reset state
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outs, '0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_reset", all_outs, '0);

        for (int i = 0; i < 10; i++) run_single(vecs[i], i);

        // Simultaneous requests, four rounds: acks must alternate m0,m1,...
        do_reset();
        seq = '0; served = 0; flag = 0;
        for (int r = 0; r < 4; r++) begin
            d0 = 0; d1 = 0; c = 0;
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 16'h0002, 32'h0202_0000 + r);
            drive(1'b1, 1'b1, 1'b1, 16'h0003, 32'h0303_0000 + r);
            while (!(d0 && d1) && c < 20) begin
                @(negedge clk);
                c++;
                if (m0_ack) begin
                    if (d0) flag = 1;
                    d0 = 1;
                    if (served < 8) seq[served] = 1'b0;
                    served++;
                    m0_req = 1'b0;
                end
                if (m1_ack) begin
                    if (d1) flag = 1;
                    d1 = 1;
                    if (served < 8) seq[served] = 1'b1;
                    served++;
                    m1_req = 1'b0;
                end
            end
        end
        check("rr_ack_count", served, 8);
        check("rr_order", seq, 8'b1010_1010);
        check("rr_dup_ack", flag, 1'b0);
        $display("txn rr: served=%0d order=%b", served, seq);

        // Reset during the WAIT cycle of an m1 read
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0001, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("wait_state", {busy, bus_addr_ctrl}, {1'b1, 32'h0001_0002});
        reset = 1'b0;
        m1_req = 1'b0;
        #1;
        check("reset_mid_wait", all_outs, '0);
        @(negedge clk);
        reset = 1'b1;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (m1_ack || busy || bus_addr_ctrl[0]) flag = 1;
        end
        check("no_activity_after_reset", flag, 1'b0);
        $display("txn reset_mid_wait: activity=%0b", flag);
        run_single(vecs[2], 10);

        // m0 holds req continuously while m1 requests: m0, m1, m0
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 16'h0004, 32'h4444_0000);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0001, 32'h0);
        seq = '0; served = 0; c = 0; d0 = 0;
        while (served < 3 && c < 40) begin
            @(negedge clk);
            c++;
            if (m0_ack) begin
                seq[served] = 1'b0;
                served++;
                if (d0) m0_req = 1'b0;
                d0 = 1;
            end
            if (m1_ack) begin
                check("cont_m1_rdata", m1_rdata, 32'hCAFE_0001);
                seq[served] = 1'b1;
                served++;
                m1_req = 1'b0;
            end
        end
        check("cont_served", served, 3);
        check("cont_order", seq[2:0], 3'b010);
        $display("txn continuous: served=%0d order=%b", served, seq[2:0]);

        // Request withdrawn right after grant still completes
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 16'h0006, 32'h6666_0006);
        @(negedge clk);
        m1_req = 1'b0;
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m1_ack) flag = 1;
        end
        check("dropped_req_ack", flag, 1'b1);
        $display("txn dropped_req: ack=%0b", flag);
        run_single('{1'b0, 1'b0, 16'h0006, 32'h0, 1'b0, 32'h6666_0006}, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
